spi_tx_sequencer: RTL and testbench
===================================

// Module: spi_tx_sequencer
// PURPOSE
//  Upstream feeder for the SPI master/slave top. Buffers outgoing words in a FIFO.
//  Issues them to the top one at a time via a single-cycle newd pulse, holding din stable.
//  Waits for done, captures the returned dout word, and guards against a hung transfer with a watchdog.
// PARAMETERS
//  DATA_W      12    width of din/dout words exchanged with the SPI top
//  DEPTH       8     FIFO entries; power of two, >= 2
//  TIMEOUT_CYC 1024  clk cycles allowed in WAIT before abort; >= 2
// PORTS
//  clk         in   1                    system clock, rising edge
//  rst         in   1                    asynchronous, active-high reset
//  in_valid    in   1                    producer offers in_data
//  in_data     in   DATA_W               word to transmit
//  in_ready    out  1                    FIFO can accept (= !full)
//  newd        out  1                    to SPI top: start transfer, 1-cycle pulse
//  din         out  DATA_W               to SPI top: word under transfer
//  done        in   1                    from SPI top: transfer complete
//  dout        in   DATA_W               from SPI top: received word
//  rx_valid    out  1                    1-cycle pulse, rx_data valid
//  rx_data     out  DATA_W               captured dout
//  level       out  $clog2(DEPTH+1)      FIFO occupancy, 0..DEPTH
//  busy        out  1                    FSM not IDLE
//  timeout_err out  1                    sticky watchdog flag
// BEHAVIOUR
//  Reset (async, any state):
//   - FIFO emptied, ptrs=0, FSM=IDLE
//   - all outputs 0; in_ready=1
//  FIFO:
//   - write on edge with in_valid&&in_ready; read/write ptrs wrap modulo DEPTH
//   - full: in_ready=0, and a write is not accepted even if a pop occurs on the same edge
//   - simultaneous write and pop when 0<level<DEPTH: level unchanged, order preserved
//  FSM:
//   - IDLE:  level!=0 -> pop head into din; go ISSUE
//   - ISSUE: newd=1 for exactly this cycle; go WAIT
//   - WAIT:  newd=0; din held; watchdog counts clk cycles in WAIT
//            * done=1: rx_data<=dout; rx_valid=1 next cycle; go IDLE
//            * count reaches TIMEOUT_CYC before done: timeout_err<=1; word dropped, no rx_valid; go IDLE
//  Latency:
//   - accept on edge E0 into empty FIFO with FSM IDLE -> newd high during the cycle after E1
//   - minimum 3-cycle spacing between successive newd pulses (WAIT->IDLE->ISSUE)
//  Other rules:
//   - done outside WAIT is ignored; no rx_valid
//   - din keeps its last value after the transfer until the next pop
//   - timeout_err clears only on rst
//   - rst mid-transfer abandons the word; SPI top is reset by the same rst
// TESTING
//  1. Write 12'hA5C, DUT loops dout=din -> newd 2 cycles after accept, then one rx_valid with rx_data=12'hA5C; level back to 0.
//  2. Hold done=0 and write 9 words -> in_ready=0 after 8, level=8, 9th not accepted; release -> 8 transfers in write order.
//  3. Back-to-back 3 words 1,2,3 -> newd pulses spaced >=3 cycles, din=1,2,3; rx_data=1,2,3.
//  4. Never assert done -> timeout_err=1 after TIMEOUT_CYC in WAIT, no rx_valid, next word issued.
//  5. Assert rst during WAIT with level=3 -> all outputs 0, level=0, in_ready=1 asynchronously.
//  6. Pulse done while IDLE -> no rx_valid, state unchanged.

Source files
------------

// File: rtl/spi_tx_sequencer.sv
// Feeds words from a FIFO to an SPI top one transfer at a time, captures the
// returned word and aborts a transfer that never completes.
module spi_tx_sequencer #(
    parameter int DATA_W      = 12,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       newd,
    output logic [DATA_W-1:0]          din,
    input  logic                       done,
    input  logic [DATA_W-1:0]          dout,
    output logic                       rx_valid,
    output logic [DATA_W-1:0]          rx_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [TMR_W-1:0]    wd_cnt;
    logic                push;
    logic                pop;
    logic                wd_expired;
    logic                rx_fire;

    // A full FIFO refuses writes even when a pop lands on the same edge.
    assign in_ready = (level != FULL_LVL);
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (level != '0) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (done || wd_expired) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        newd       = (state == S_ISSUE);
        busy       = (state != S_IDLE);
        pop        = (state == S_IDLE) && (level != '0);
        rx_fire    = (state == S_WAIT) && done;
        wd_expired = (state == S_WAIT) && !done && (wd_cnt == TMR_LAST);
    end

    // Storage carries no reset; only pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Watchdog restarts on every entry to WAIT, so WAIT lasts at most TIMEOUT_CYC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state != S_WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) din <= mem[rd_ptr];
            if (rx_fire) rx_data <= dout;
            rx_valid <= rx_fire;
            if (wd_expired) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Bench for spi_tx_sequencer: loopback SPI responder, scoreboard queues for
// issued and returned words, plus directed corner sequences.
module tb_spi_tx_sequencer;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 8;
    localparam int TOUT   = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              newd;
    logic [DATA_W-1:0] din;
    logic              done;
    logic [DATA_W-1:0] dout;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [3:0]        level;
    logic              busy;
    logic              timeout_err;

    logic              resp_done;
    logic              force_done;
    logic [DATA_W-1:0] resp_dout;
    bit                resp_en;

    assign done = resp_done | force_done;
    assign dout = resp_dout;

    spi_tx_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .newd(newd), .din(din), .done(done), .dout(dout),
        .rx_valid(rx_valid), .rx_data(rx_data), .level(level), .busy(busy),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] din_q[$];
    logic [DATA_W-1:0] rx_q[$];

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              exp_ready;
        logic [3:0]        exp_level;
    } vec_t;

    vec_t fill_tbl[9];
    vec_t b2b_tbl[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Loopback SPI top: answers done (dout = din) resp_dly cycles into WAIT.
    int resp_dly = 0;
    initial begin : responder
        int wcnt;
        wcnt      = 0;
        resp_done = 1'b0;
        resp_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_done) begin
                resp_done = 1'b0;
                wcnt      = 0;
            end else if (resp_en && busy && !newd) begin
                if (wcnt >= resp_dly) begin
                    resp_done = 1'b1;
                    resp_dout = din;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard monitor on the falling edge.
    initial begin : monitor
        int  cyc;
        int  last_cyc;
        bit  have_last;
        cyc       = 0;
        last_cyc  = 0;
        have_last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                have_last = 0;
            end else begin
                if (newd) begin
                    if (din_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL newd_unexpected: got newd=1 din=%0h required no pulse", din);
                    end else begin
                        chk("newd_din", din, din_q.pop_front());
                    end
                    if (have_last) chk("newd_spacing_ge3", (cyc - last_cyc) >= 3, 1);
                    last_cyc  = cyc;
                    have_last = 1;
                end
                if (rx_valid) begin
                    if (rx_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rx_unexpected: got rx_valid=1 rx_data=%0h required no pulse", rx_data);
                    end else begin
                        chk("rx_data", rx_data, rx_q.pop_front());
                    end
                end
            end
        end
    end

    // Caller sits at a falling edge; returns at the falling edge after the write edge.
    task automatic write_word(input logic [DATA_W-1:0] d, input bit exp_rx, output bit acc);
        in_valid = 1'b1;
        in_data  = d;
        acc      = in_ready;
        if (acc) begin
            din_q.push_back(d);
            if (exp_rx) rx_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n;
        n = 0;
        while ((busy || level != 0 || din_q.size() != 0 || rx_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got still busy after %0d cycles required idle (level=%0d din_q=%0d rx_q=%0d)",
                     name, n, level, din_q.size(), rx_q.size());
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        bit acc;
        int n;

        for (int i = 0; i < 9; i++) begin
            fill_tbl[i].data      = DATA_W'(12'h100 + i + 1);
            fill_tbl[i].exp_ready = (i < 8);
            fill_tbl[i].exp_level = (i < 8) ? 4'(i + 1) : 4'd8;
        end
        b2b_tbl[0] = '{12'h001, 1'b1, 4'd1};
        b2b_tbl[1] = '{12'h002, 1'b1, 4'd1};
        b2b_tbl[2] = '{12'h003, 1'b1, 4'd2};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; force_done = 1'b0; resp_en = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_newd", newd, 0);
        chk("rst_din", din, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word with loopback: newd two edges after the accept.
        write_word(12'hA5C, 1, acc);
        chk("t1_accept", acc, 1);
        chk("t1_level_after_accept", level, 1);
        chk("t1_newd_not_yet", newd, 0);
        @(negedge clk);
        chk("t1_newd_high", newd, 1);
        wait_idle("t1_idle", 50);
        chk("t1_level_zero", level, 0);

        // Fill while one transfer is stuck in WAIT.
        resp_en = 0;
        write_word(12'h0FF, 1, acc);
        repeat (2) @(negedge clk);
        chk("t2_stuck_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            chk("t2_in_ready", in_ready, fill_tbl[i].exp_ready);
            write_word(fill_tbl[i].data, 1, acc);
            chk("t2_accept", acc, fill_tbl[i].exp_ready);
            chk("t2_level", level, fill_tbl[i].exp_level);
        end
        chk("t2_full_in_ready", in_ready, 0);
        chk("t2_din_held", din, 12'h0FF);
        resp_en = 1;
        wait_idle("t2_drain", 200);
        chk("t2_in_ready_after", in_ready, 1);

        // Back-to-back writes.
        for (int i = 0; i < 3; i++) begin
            write_word(b2b_tbl[i].data, 1, acc);
            chk("t3_accept", acc, b2b_tbl[i].exp_ready);
            chk("t3_level", level, b2b_tbl[i].exp_level);
        end
        wait_idle("t3_idle", 100);
        chk("t3_din_kept", din, 12'h003);

        // Watchdog: no done for the first word, the next word still goes through.
        resp_en = 0;
        write_word(12'h7E1, 0, acc);
        n = 0;
        while (!newd && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_newd_seen", newd, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < TOUT + 10);
        chk("t4_timeout_cycles", n, TOUT + 1);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_busy_after", busy, 0);
        resp_en = 1;
        write_word(12'h2B4, 1, acc);
        wait_idle("t4_next_word", 50);
        chk("t4_err_sticky", timeout_err, 1);

        // Asynchronous reset during WAIT with three words queued.
        resp_en = 0;
        write_word(12'h011, 0, acc);
        write_word(12'h022, 0, acc);
        write_word(12'h033, 0, acc);
        write_word(12'h044, 0, acc);
        chk("t5_level_pre", level, 3);
        chk("t5_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_level", level, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_newd", newd, 0);
        chk("t5_din", din, 0);
        chk("t5_rx_valid", rx_valid, 0);
        chk("t5_rx_data", rx_data, 0);
        chk("t5_timeout_err", timeout_err, 0);
        din_q.delete();
        rx_q.delete();
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1;
        @(negedge clk);

        // done while IDLE is ignored.
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_rx_valid", rx_valid, 0);
        @(negedge clk);
        chk("t6_rx_valid_late", rx_valid, 0);
        chk("t6_level", level, 0);

        write_word(12'h3C3, 1, acc);
        wait_idle("t6_after", 50);
        chk("final_din_q_empty", din_q.size(), 0);
        chk("final_rx_q_empty", rx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
